// File: rtl/exec_ctrl.sv
// exec_ctrl
// Multi-cycle execute controller wrapped around the CR16 ALU. Each instruction
// is accepted in IDLE. Its operands are read from an internal 16-entry
// register file in READ, and the ALU is enabled for one cycle in EXEC. In WB
// the result is written back and the processor status register is updated.
//
// Ports
//   I_CLK, I_RESET           clock, synchronous active-high reset
//   I_VALID / O_READY        instruction request handshake (transfer on both high)
//   I_OPCODE                 ALU opcode (0-11 defined, 12-15 retire as no-ops)
//   I_RDST, I_RSRC           destination (B operand) and source (A operand) registers
//   I_USE_IMM, I_IMM         take A from the 8-bit immediate instead of Rsrc
//   I_WRITEBACK              0 = compare-style, only PSR is updated
//   O_DONE                   one-cycle retire pulse
//   O_RESULT                 result of the last retired instruction
//   O_PSR                    {N,Z,F,L,C}
//   O_ALU_*                  ALU enable/opcode/operands, zero outside EXEC
//   I_ALU_C, I_ALU_STATUS    ALU result and flags
//   I_DBG_ADDR, O_DBG_DATA   combinational register-file read port
module exec_ctrl #(
    parameter int P_WIDTH = 16,
    parameter int P_REGS  = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_VALID,
    output logic               O_READY,
    input  logic [3:0]         I_OPCODE,
    input  logic [3:0]         I_RDST,
    input  logic [3:0]         I_RSRC,
    input  logic               I_USE_IMM,
    input  logic [7:0]         I_IMM,
    input  logic               I_WRITEBACK,
    output logic               O_DONE,
    output logic [P_WIDTH-1:0] O_RESULT,
    output logic [4:0]         O_PSR,
    output logic               O_ALU_ENABLE,
    output logic [3:0]         O_ALU_OPCODE,
    output logic [P_WIDTH-1:0] O_ALU_A,
    output logic [P_WIDTH-1:0] O_ALU_B,
    input  logic [P_WIDTH-1:0] I_ALU_C,
    input  logic [4:0]         I_ALU_STATUS,
    input  logic [3:0]         I_DBG_ADDR,
    output logic [P_WIDTH-1:0] O_DBG_DATA
);

    localparam logic [3:0] OPC_MUL  = 4'd2;
    localparam logic [3:0] OPC_LAST = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t state_q, state_d;

    // Instruction registers
    logic [3:0]         opc_q, opc_d;
    logic [3:0]         rdst_q, rdst_d;
    logic [3:0]         rsrc_q, rsrc_d;
    logic               use_imm_q, use_imm_d;
    logic [7:0]         imm_q, imm_d;
    logic               wb_q, wb_d;

    // Operand, result and status registers
    logic [P_WIDTH-1:0] op_a_q, op_a_d;
    logic [P_WIDTH-1:0] op_b_q, op_b_d;
    logic [P_WIDTH-1:0] result_q, result_d;
    logic [4:0]         stat_q, stat_d;
    logic [4:0]         psr_q, psr_d;

    logic [P_WIDTH-1:0] regs_q [P_REGS];
    logic               rf_we;
    logic               opc_defined;

    // Arithmetic opcodes (ADD, ADDC, MUL, SUB) take a signed immediate;
    // logical and shift opcodes take it zero-extended.
    function automatic logic [P_WIDTH-1:0] ext_imm(input logic [3:0] opc,
                                                   input logic [7:0] imm);
        if (opc <= 4'd3) begin
            return {{(P_WIDTH-8){imm[7]}}, imm};
        end
        return {{(P_WIDTH-8){1'b0}}, imm};
    endfunction

    assign opc_defined = (opc_q <= OPC_LAST);
    assign O_RESULT    = result_q;
    assign O_PSR       = psr_q;
    assign O_DBG_DATA  = regs_q[I_DBG_ADDR];

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        rdst_d       = rdst_q;
        rsrc_d       = rsrc_q;
        use_imm_d    = use_imm_q;
        imm_d        = imm_q;
        wb_d         = wb_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        stat_d       = stat_q;
        psr_d        = psr_q;
        rf_we        = 1'b0;
        O_READY      = 1'b0;
        O_DONE       = 1'b0;
        O_ALU_ENABLE = 1'b0;
        O_ALU_OPCODE = '0;
        O_ALU_A      = '0;
        O_ALU_B      = '0;

        unique case (state_q)
            S_IDLE: begin
                O_READY = 1'b1;
                if (I_VALID) begin
                    opc_d     = I_OPCODE;
                    rdst_d    = I_RDST;
                    rsrc_d    = I_RSRC;
                    use_imm_d = I_USE_IMM;
                    imm_d     = I_IMM;
                    wb_d      = I_WRITEBACK;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                // Both operands see the pre-write register contents, so
                // Rsrc == Rdst needs no special handling.
                op_b_d  = regs_q[rdst_q];
                op_a_d  = use_imm_q ? ext_imm(opc_q, imm_q) : regs_q[rsrc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                O_ALU_ENABLE = 1'b1;
                O_ALU_OPCODE = opc_q;
                O_ALU_A      = op_a_q;
                O_ALU_B      = op_b_q;
                // Undefined opcodes still retire, but report a zero result.
                result_d     = opc_defined ? I_ALU_C : '0;
                stat_d       = I_ALU_STATUS;
                state_d      = S_WB;
            end
            S_WB: begin
                O_DONE = 1'b1;
                rf_we  = wb_q & opc_defined;
                // MUL leaves the flags untouched.
                if (opc_defined && (opc_q != OPC_MUL)) begin
                    psr_d = stat_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            rdst_q    <= '0;
            rsrc_q    <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            wb_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            stat_q    <= '0;
            psr_q     <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            rdst_q    <= rdst_d;
            rsrc_q    <= rsrc_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            wb_q      <= wb_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            result_q  <= result_d;
            stat_q    <= stat_d;
            psr_q     <= psr_d;
        end
    end

    // Register file: no hardwired zero register, every entry is writable.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int i = 0; i < P_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rdst_q] <= result_q;
        end
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Multi-cycle execute controller for the CR16 datapath. It accepts one register/immediate instruction per handshake and reads operands from an internal 16-entry register file. It drives the ALU operand/opcode ports, captures the ALU result and status, writes the result back and latches the processor status register (PSR). It sits directly around the ALU: upstream as the operand source, downstream as the result/status consumer.

## Interface
- P_WIDTH, 16, datapath width; must match the ALU width
- P_REGS, 16, register-file depth; fixed at 16 because of the 4-bit register addresses

Ports:
- I_CLK  input  1  system clock; all state changes on rising edge
- I_RESET  input  1  synchronous, active-high reset
- I_VALID  input  1  instruction request valid
- O_READY  output  1  controller idle and able to accept
- I_OPCODE  input  4  ALU opcode: 0 ADD, 1 ADDC, 2 MUL, 3 SUB, 4 NOT, 5 AND, 6 OR, 7 XOR, 8 LSH, 9 RSH, 10 ALSH, 11 ARSH; 12-15 undefined
- I_RDST  input  4  destination register; also supplies the B operand
- I_RSRC  input  4  source register; supplies the A operand when I_USE_IMM=0
- I_USE_IMM  input  1  A operand taken from I_IMM instead of Rsrc
- I_IMM  input  8  immediate value
- I_WRITEBACK  input  1  write the result to Rdst; 0 gives compare-style operation (PSR only)
- O_DONE  output  1  one-cycle pulse: instruction retired
- O_RESULT  output  P_WIDTH  result of the last retired instruction
- O_PSR  output  5  status register {N,Z,F,L,C}; bit0 C, 1 L, 2 F, 3 Z, 4 N
- O_ALU_ENABLE  output  1  ALU enable
- O_ALU_OPCODE  output  4  ALU opcode
- O_ALU_A  output  P_WIDTH  ALU operand A (source)
- O_ALU_B  output  P_WIDTH  ALU operand B (destination value)
- I_ALU_C  input  P_WIDTH  ALU result
- I_ALU_STATUS  input  5  ALU status flags
- I_DBG_ADDR  input  4  debug read address
- O_DBG_DATA  output  P_WIDTH  combinational register-file read of I_DBG_ADDR

## Operation
- The FSM has four states: IDLE, READ, EXEC, WB. The next state after WB is always IDLE.
- IDLE:
  - O_READY=1.
  - On I_VALID=1, capture opcode, Rdst, Rsrc, USE_IMM, IMM and WRITEBACK into instruction registers, then go to READ.
- READ:
  - Load operand B = reg[Rdst].
  - Load operand A = reg[Rsrc], or the extended immediate when USE_IMM=1.
  - Immediate extension: sign-extend for opcodes 0-3; zero-extend for opcodes 4-11.
- EXEC:
  - O_ALU_ENABLE=1; O_ALU_OPCODE, O_ALU_A and O_ALU_B driven from registers.
  - At the end of EXEC, capture I_ALU_C into the result register and I_ALU_STATUS into the status-capture register.
- WB:
  - O_DONE=1 and O_RESULT is valid.
  - At the WB edge, reg[Rdst] is written with the result if WRITEBACK=1 and the opcode is 0-11.
  - At the same edge, PSR is loaded from the captured status for opcodes 0,1,3-11. PSR is held for MUL (2), which preserves the flags.
- Undefined opcodes 12-15: the full handshake still completes (O_DONE pulses) with O_RESULT=0, no register write and PSR unchanged.
- Outside EXEC: O_ALU_ENABLE=0, O_ALU_OPCODE=0, O_ALU_A=0, O_ALU_B=0.
- Rsrc==Rdst is legal; both operands read the same pre-write value.
- All 16 registers are writable; there is no hardwired zero register.

## Timing
- Reset values:
  - FSM in IDLE, O_READY=1, O_DONE=0, O_RESULT=0, O_PSR=0.
  - All ALU outputs 0; all registers 0.
  - O_DBG_DATA therefore reads 0.
- Reset mid-operation (any state): the instruction is abandoned with no writeback and no PSR update. The next cycle is IDLE with all state cleared.
- Latency and throughput:
  - Accept edge = cycle 0. READ in cycle 1, EXEC in cycle 2, WB (O_DONE high) in cycle 3.
  - O_READY returns high in cycle 4.
  - Throughput is one instruction per 4 cycles.
- Handshake:
  - Transfer occurs only on I_VALID & O_READY.
  - O_READY is low in READ/EXEC/WB, and I_VALID is ignored there; the requester holds its request.
  - Back-to-back requests: the next instruction is accepted on the first IDLE cycle after WB.
- O_DBG_DATA reflects a WB write starting the cycle after the WB edge.
- O_RESULT and O_PSR hold their values until the next WB or reset.
- ADDC uses the ALU's ADDC semantics unchanged. The controller does not feed the PSR carry into it.

## Test plan
- Reset, then ADD r1, imm 8'h05 -> O_DONE in cycle 3 after accept, O_RESULT=16'h0005, O_DBG_DATA[r1]=16'h0005, O_PSR=5'b00000.
- With r1=5: SUB r1, imm 8'h07, WRITEBACK=0 -> r1 stays 16'h0005, O_RESULT=16'hFFFE, O_PSR=5'b10011 (N,L,C set).
- ADD r2, imm 8'hFF then AND r2, imm 8'hFF -> r2=16'hFFFF after the first (sign extension), 16'h00FF after the second (zero extension), Z=0.
- MUL r1,r1 (r1=5) after the SUB compare -> r1=16'h0019, O_PSR unchanged at 5'b10011. Then opcode 13 -> O_DONE pulses, O_RESULT=0, no register change.
- Hold I_VALID high continuously for three instructions -> accepts exactly 4 cycles apart, O_READY low for 3 cycles after each accept.
- Assert I_RESET during EXEC of ADD r3, imm 8'h01 -> no O_DONE, r3=0, O_PSR=0, O_READY=1 the following cycle.
